// File: rtl/multicore_ctrl.sv
// multicore_ctrl: staggered per-core reset release plus a registered valid/ready output arbiter.
// Define MULTICORE_CTRL_RR_EN for round-robin arbitration; otherwise the lowest eligible index wins.
module multicore_ctrl #(
    parameter int NCORES  = 21,
    parameter int DW      = 31,
    parameter int ENW     = 4,
    parameter int STAGGER = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [NCORES-1:0]     core_rst,
    input  logic [NCORES*DW-1:0]  core_io_out,
    input  logic [NCORES*ENW-1:0] core_out_en,
    output logic [NCORES-1:0]     core_ack,
    output logic [DW-1:0]         io_out,
    output logic [ENW-1:0]        out_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  seq_done
);
    localparam int IW = $clog2(NCORES);
    localparam int CW = (STAGGER > 1) ? $clog2(STAGGER) : 1;

    typedef enum logic {S_RELEASE, S_DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     idx_q;
    logic [NCORES-1:0] core_rst_q;
    logic              seq_done_q;

    logic [NCORES-1:0] core_ack_q, core_ack_d;
    logic [DW-1:0]     io_out_q, io_out_d;
    logic [ENW-1:0]    out_en_q, out_en_d;
    logic              out_valid_q, out_valid_d;

    logic [NCORES-1:0] elig;
    logic              found;
    logic [IW-1:0]     win;

    // Core idx_q is released whenever the stagger counter sits at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RELEASE;
            cnt_q      <= '0;
            idx_q      <= '0;
            core_rst_q <= '1;
            seq_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_RELEASE: begin
                    cnt_q <= (cnt_q == CW'(STAGGER - 1)) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == '0) begin
                        core_rst_q[idx_q] <= 1'b0;
                        if (idx_q == IW'(NCORES - 1)) begin
                            state_q    <= S_DONE;
                            seq_done_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // A core is masked while its ack is high so a stale request is never granted twice.
    generate
        for (genvar gi = 0; gi < NCORES; gi++) begin : g_elig
            assign elig[gi] = ~core_rst_q[gi] & (|core_out_en[gi*ENW +: ENW]) & ~core_ack_q[gi];
        end
    endgenerate

`ifdef MULTICORE_CTRL_RR_EN
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [2*NCORES-1:0] elig_dbl;
    logic [NCORES-1:0]   elig_rot;
    logic [IW-1:0]       off;
    logic [IW:0]         sum;

    always_comb begin
        elig_dbl = {elig, elig} >> ptr_q;
        elig_rot = elig_dbl[NCORES-1:0];
        found    = 1'b0;
        off      = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (elig_rot[i]) begin
                found = 1'b1;
                off   = IW'(i);
            end
        end
        sum = {1'b0, ptr_q} + {1'b0, off};
        win = (sum >= (IW+1)'(NCORES)) ? IW'(sum - (IW+1)'(NCORES)) : IW'(sum);
    end
`else
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (elig[i]) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        io_out_d    = io_out_q;
        out_en_d    = out_en_q;
        core_ack_d  = '0;
`ifdef MULTICORE_CTRL_RR_EN
        ptr_d       = ptr_q;
`endif
        if (!out_valid_q || out_ready) begin
            if (found) begin
                out_valid_d = 1'b1;
                io_out_d    = core_io_out[win*DW +: DW];
                out_en_d    = core_out_en[win*ENW +: ENW];
                core_ack_d  = NCORES'(1) << win;
`ifdef MULTICORE_CTRL_RR_EN
                ptr_d       = (win == IW'(NCORES - 1)) ? '0 : win + 1'b1;
`endif
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            io_out_q    <= '0;
            out_en_q    <= '0;
            core_ack_q  <= '0;
`ifdef MULTICORE_CTRL_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            io_out_q    <= io_out_d;
            out_en_q    <= out_en_d;
            core_ack_q  <= core_ack_d;
`ifdef MULTICORE_CTRL_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign core_rst  = core_rst_q;
    assign core_ack  = core_ack_q;
    assign io_out    = io_out_q;
    assign out_en    = out_en_q;
    assign out_valid = out_valid_q;
    assign seq_done  = seq_done_q;
endmodule

// File: tb/tb_multicore_ctrl.sv
// Bench for multicore_ctrl: directed plan steps then random traffic, checked against an edge-count model.
module tb_multicore_ctrl;
    localparam int N   = 4;
    localparam int DW  = 31;
    localparam int ENW = 4;
    localparam int S   = 3;

    logic clk = 1'b0;
    logic rst;
    logic out_ready;
    logic [N-1:0]     core_rst, core_ack;
    logic [N*DW-1:0]  core_io_out;
    logic [N*ENW-1:0] core_out_en;
    logic [DW-1:0]    io_out;
    logic [ENW-1:0]   out_en;
    logic             out_valid, seq_done;

    logic [DW-1:0]  d_a [N];
    logic [ENW-1:0] e_a [N];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: releases derive from edges seen since reset; one output slot plus ack vector.
    int             m_edges = 0;
    logic           m_valid = 1'b0;
    logic [DW-1:0]  m_data  = '0;
    logic [ENW-1:0] m_en    = '0;
    logic [N-1:0]   m_ack   = '0;
`ifdef MULTICORE_CTRL_RR_EN
    int             m_ptr   = 0;
`endif

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign core_io_out[gi*DW +: DW]   = d_a[gi];
            assign core_out_en[gi*ENW +: ENW] = e_a[gi];
        end
    endgenerate

    multicore_ctrl #(.NCORES(N), .DW(DW), .ENW(ENW), .STAGGER(S)) dut (
        .clk(clk), .rst(rst), .core_rst(core_rst), .core_io_out(core_io_out),
        .core_out_en(core_out_en), .core_ack(core_ack), .io_out(io_out), .out_en(out_en),
        .out_valid(out_valid), .out_ready(out_ready), .seq_done(seq_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i] === 1'b1) r = i;
        return r;
    endfunction

    task automatic tick();
        logic           r, rdy;
        logic [DW-1:0]  dd [N];
        logic [ENW-1:0] ee [N];
        logic [N-1:0]   el, nack, exp_rst;
        int             w, k;
        r   = rst;
        rdy = out_ready;
        for (int i = 0; i < N; i++) begin
            dd[i] = d_a[i];
            ee[i] = e_a[i];
        end
        @(posedge clk);
        if (r) begin
            m_edges = 0;
            m_valid = 1'b0;
            m_ack   = '0;
`ifdef MULTICORE_CTRL_RR_EN
            m_ptr   = 0;
`endif
        end else begin
            for (int i = 0; i < N; i++)
                el[i] = (m_edges >= 1 + i*S) && (ee[i] != '0) && !m_ack[i];
            nack = '0;
            if (!m_valid || rdy) begin
                w = -1;
                for (int i = 0; i < N; i++) begin
`ifdef MULTICORE_CTRL_RR_EN
                    k = (m_ptr + i) % N;
`else
                    k = i;
`endif
                    if (w < 0 && el[k]) w = k;
                end
                if (w >= 0) begin
                    m_valid = 1'b1;
                    m_data  = dd[w];
                    m_en    = ee[w];
                    nack[w] = 1'b1;
`ifdef MULTICORE_CTRL_RR_EN
                    m_ptr   = (w + 1) % N;
`endif
                end else begin
                    m_valid = 1'b0;
                end
            end
            m_ack = nack;
            if (m_edges < 100000) m_edges++;
        end
        #1;
        cyc++;
        for (int i = 0; i < N; i++) exp_rst[i] = !(m_edges >= 1 + i*S);
        chk("core_rst", 64'(core_rst), 64'(exp_rst));
        chk("seq_done", 64'(seq_done), 64'(m_edges >= 1 + (N-1)*S));
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("core_ack", 64'(core_ack), 64'(m_ack));
        if (m_valid) begin
            chk("io_out", 64'(io_out), 64'(m_data));
            chk("out_en", 64'(out_en), 64'(m_en));
        end
        if (core_ack != '0)
            $display("[TB] cyc %0d ack %b io_out %0d out_en %0h", cyc, core_ack, $signed(io_out), out_en);
    endtask

    initial begin
        int rel_edge [N];
        int done_edge, ack_cnt, wi;
        int exp_order [5];
        logic [DW-1:0] neg5, w0, w1, w3;

        rst = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            d_a[i] = '0;
            e_a[i] = '0;
        end
        tick();
        tick();
        chk("rst_core_rst", 64'(core_rst), 64'(4'hF));
        chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_io_out", 64'(io_out), 64'(0));
        chk("rst_out_en", 64'(out_en), 64'(0));
        chk("rst_core_ack", 64'(core_ack), 64'(0));
        chk("rst_seq_done", 64'(seq_done), 64'(1'b0));

        // Release spacing with no requests.
        rst = 1'b0;
        for (int i = 0; i < N; i++) rel_edge[i] = -1;
        done_edge = -1;
        ack_cnt = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            for (int i = 0; i < N; i++)
                if (rel_edge[i] < 0 && core_rst[i] === 1'b0) rel_edge[i] = e;
            if (done_edge < 0 && seq_done === 1'b1) done_edge = e;
            if (core_ack !== '0) ack_cnt++;
        end
        for (int i = 0; i < N; i++)
            chk($sformatf("release_edge_core%0d", i), 64'(rel_edge[i]), 64'(1 + i*S));
        chk("seq_done_edge", 64'(done_edge), 64'(10));
        chk("release_no_ack", 64'(ack_cnt), 64'(0));

        // Single transfer of a negative word from core 2.
        neg5 = -31'sd5;
        d_a[2] = neg5;
        e_a[2] = 4'd1;
        out_ready = 1'b1;
        tick();
        chk("single_io_out", 64'(io_out), 64'(neg5));
        chk("single_out_en", 64'(out_en), 64'(4'd1));
        chk("single_valid", 64'(out_valid), 64'(1'b1));
        chk("single_ack", 64'(core_ack), 64'(4'b0100));
        e_a[2] = '0;
        tick();
        tick();

        // Back-pressure: first word holds while out_ready is low.
        w0 = 31'h0123_4567;
        w1 = 31'h7000_0001;
        d_a[0] = w0; e_a[0] = 4'd3;
        d_a[1] = w1; e_a[1] = 4'hA;
        out_ready = 1'b0;
        ack_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            e_a[0] = '0;
            if (core_ack !== '0) ack_cnt++;
            chk("bp_hold_io_out", 64'(io_out), 64'(w0));
            chk("bp_hold_valid", 64'(out_valid), 64'(1'b1));
        end
        chk("bp_single_ack", 64'(ack_cnt), 64'(1));
        out_ready = 1'b1;
        tick();
        chk("bp_second_io_out", 64'(io_out), 64'(w1));
        chk("bp_second_ack", 64'(core_ack), 64'(4'b0010));
        e_a[1] = '0;
        tick();

        // Mid-run reset while a word is held and core 2 is still in reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        d_a[0] = 31'h0000_0055;
        e_a[0] = 4'd5;
        tick();
        chk("rel_same_cycle_core_rst0", 64'(core_rst[0]), 64'(1'b0));
        chk("rel_same_cycle_no_valid", 64'(out_valid), 64'(1'b0));
        tick();
        e_a[0] = '0;
        chk("pre_reset_valid", 64'(out_valid), 64'(1'b1));
        chk("pre_reset_core2_held", 64'(core_rst[2]), 64'(1'b1));
        rst = 1'b1;
        tick();
        chk("midrst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("midrst_core_rst", 64'(core_rst), 64'(4'hF));
        chk("midrst_core_ack", 64'(core_ack), 64'(0));
        rst = 1'b0;
        tick();
        chk("restart_core_rst", 64'(core_rst), 64'(4'hE));

        // Core 3 requests before its release edge (edge 10).
        out_ready = 1'b1;
        w3 = 31'h2AAA_5555;
        d_a[3] = w3;
        e_a[3] = 4'd2;
        for (int e = 2; e <= 10; e++) begin
            tick();
            chk("unreleased_no_ack3", 64'(core_ack[3]), 64'(1'b0));
        end
        tick();
        chk("released_ack3", 64'(core_ack), 64'(4'b1000));
        chk("released_io_out3", 64'(io_out), 64'(w3));
        chk("released_out_en3", 64'(out_en), 64'(4'd2));
        e_a[3] = '0;
        tick();
        tick();

        // Arbitration order with all cores requesting continuously.
`ifdef MULTICORE_CTRL_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 1, 0, 1, 0};
`endif
        for (int i = 0; i < N; i++) begin
            d_a[i] = DW'(32'h100 + i);
            e_a[i] = 4'd1;
        end
        for (int g = 0; g < 5; g++) begin
            tick();
            wi = onehot_idx(core_ack);
            chk($sformatf("arb_grant_%0d", g), 64'(wi), 64'(exp_order[g]));
        end
        for (int i = 0; i < N; i++) e_a[i] = '0;
        tick();
        tick();

        // Random traffic, back-pressure and occasional resets.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                e_a[i] = ($urandom_range(0, 1) == 1) ? ENW'($urandom_range(1, 15)) : '0;
                d_a[i] = DW'($urandom);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicore_ctrl.md
# multicore_ctrl

Parametrised reset sequencer and output arbiter for an array of `rede` cores. Releases each core from reset in turn, a fixed number of cycles apart, so start-up inrush and input-request bursts are spread out. Merges the cores' output words onto one registered output port with a valid/ready handshake, and returns a per-core acknowledge. Sits between the core array and the shared output path; the cores themselves are instantiated alongside it, not inside it.

## Interface
Parameters:
- `NCORES`, default 21: number of cores, from 2 to 256.
- `DW`, default 31: output data width in bits (signed).
- `ENW`, default 4: per-core out_en width.
- `STAGGER`, default 25: number of cycles between successive core reset releases, at least 1.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `core_rst`  out  NCORES: per-core reset; bit k drives core k.
- `core_io_out`  in  NCORES*DW: core k's output word sits at bits [k*DW +: DW].
- `core_out_en`  in  NCORES*ENW: core k's out_en sits at bits [k*ENW +: ENW]. Any nonzero value is a request.
- `core_ack`  out  NCORES: one-cycle grant acknowledge to each core.
- `io_out`  out  DW: merged output word.
- `out_en`  out  ENW: out_en of the granted core.
- `out_valid`  out  1: `io_out` and `out_en` hold a word.
- `out_ready`  in  1: the downstream side accepts the word.
- `seq_done`  out  1: every core has been released from reset.

## Operation
**Reset values** while `rst` is high:
- `core_rst` all ones.
- `core_ack`, `out_valid`, `io_out`, `out_en` all zero.
- `seq_done` 0.
- Release counter and core index 0; round-robin pointer 0.

**Sequencer**, states RELEASE and DONE:
- RELEASE: at the first edge with `rst` low, `core_rst[0]` goes to 0.
- Each further core then clears STAGGER edges after the previous one: core k clears at edge 1 + k*STAGGER.
- The counter runs from 0 to STAGGER-1 and wraps.
- When core NCORES-1 clears, the state moves to DONE and `seq_done` goes to 1 at that same edge.
- DONE has no exit except `rst`.

**Arbiter**:
- Eligible requester: core k with `core_rst[k]`=0, a nonzero out_en, and `core_ack[k]`=0 in the current cycle.
- The output register may load when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1.
- On a load with at least one eligible requester, the winner's `io_out` and `out_en` are captured. `out_valid` goes to 1, and `core_ack[winner]` goes to 1 for exactly the next cycle.
- A transfer with no eligible requester clears `out_valid` to 0.
- While `out_valid`=1 and `out_ready`=0, the output register holds and no core is acked.
- Cores must change or drop out_en at the edge where they sample `core_ack`.
- Arithmetic: none; data passes through unmodified, sign preserved.

## Timing
- Request to output: a request present in cycle t is visible on `io_out`/`out_valid` in cycle t+1; `core_ack` is high in cycle t+1.
- Throughput: one word per cycle while `out_ready`=1 and requests are present.
- Back-to-back requests from the same core: at most one grant every 2 cycles, because the core is masked while its ack is high.
- Reset asserted mid-operation: at the next edge every output returns to its reset value, any held word is discarded, and the sequencer restarts from core 0.
- A request and release in the same cycle: core k is not eligible in the cycle where `core_rst[k]` is still 1.

## Configuration
- Macro `MULTICORE_CTRL_RR_EN`.
- Defined: round-robin arbitration. The search starts at the pointer; after a grant to core i the pointer becomes (i+1) mod NCORES, wrapping from NCORES-1 to 0.
- Undefined: fixed priority, lowest eligible index wins, and the pointer logic is removed.

## Test plan
Bench parameters: NCORES=4, DW=31, ENW=4, STAGGER=3.
- **Release spacing:** `rst` 1→0 with no requests → `core_rst` clears at edges 1, 4, 7, 10; `seq_done` rises at edge 10; no ack is issued.
- **Single transfer:** with all cores released, core 2 drives out_en=1 and io_out=-5 for one cycle, `out_ready`=1 → next cycle `io_out`=-5, `out_en`=1, `out_valid`=1, `core_ack`=0100.
- **Back-pressure:** cores 0 and 1 request, `out_ready`=0 for 4 cycles → the first word holds for 4 cycles and only one ack is issued; after `out_ready` rises the second word follows 1 cycle later.
- **Arbitration order:** all 4 cores request continuously, `out_ready`=1, RR build → grant order 0, 1, 2, 3, 0. Non-RR build → grant order 0, 1, 0, 1.
- **Mid-run reset:** pulse `rst` while `out_valid`=1 and core 2 is still held in reset → `out_valid`=0 and `core_rst`=1111 at the next edge; sequencing restarts and core 0 clears 1 edge after `rst` falls.
- **Unreleased requester:** core 3 drives out_en=2 before its release edge → no grant; it is granted 1 cycle after `core_rst[3]` clears.
